// File: rtl/vga_pkg.sv
// vga_pkg: shared timing and tile-geometry constants for the snake-game VGA core.
// Optional build macro VGA_SYNC_EN (see vga_controller) uses the porch/sync
// constants below; the counters always use the totals.
package vga_pkg;

  // Counter widths
  localparam int CNT_W   = 10;  // row/col/raddr width
  localparam int FRAME_W = 5;   // frame counter / next_duration width

  // Horizontal timing in pixel clocks
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800

  // Vertical timing in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  // Tile geometry: 32x32 pixel tiles, 20 tiles across the visible width
  localparam int TILE_SHIFT = 5;
  localparam int GRID_W     = H_ACTIVE >> TILE_SHIFT;

  // Current pixel position as produced by the timing counters
  typedef struct packed {
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
  } pix_pos_t;

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running row/col raster counters over the full frame,
// plus a one-cycle pulse at the first pixel of vertical blanking.
module vga_timing
  import vga_pkg::*;
#(
  parameter int P_H_TOTAL  = H_TOTAL,
  parameter int P_V_TOTAL  = V_TOTAL,
  parameter int P_V_ACTIVE = V_ACTIVE
) (
  input  logic     clk,
  input  logic     reset,          // synchronous, active-low
  output pix_pos_t o_pos,
  output logic     o_vblank_start
);

  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic             w_line_end;
  logic             w_frame_end;

  assign w_line_end  = (r_col == CNT_W'(P_H_TOTAL - 1));
  assign w_frame_end = w_line_end && (r_row == CNT_W'(P_V_TOTAL - 1));

  // Column counter: advances every clock, wraps at the end of each line
  always_ff @(posedge clk) begin
    if (!reset)          r_col <= '0;
    else if (w_line_end) r_col <= '0;
    else                 r_col <= r_col + CNT_W'(1);
  end

  // Row counter: advances on line wrap, wraps at the end of the frame
  always_ff @(posedge clk) begin
    if (!reset)           r_row <= '0;
    else if (w_frame_end) r_row <= '0;
    else if (w_line_end)  r_row <= r_row + CNT_W'(1);
  end

  assign o_pos.row      = r_row;
  assign o_pos.col      = r_col;
  // First pixel of the first blanking line; used as the once-per-frame tick
  assign o_vblank_start = (r_row == CNT_W'(P_V_ACTIVE)) && (r_col == '0);

endmodule

// File: rtl/vga_controller.sv
// vga_controller: pixel-timing core for the 640x480@60 snake display.
// Produces row/col, the tile-RAM read address/enable for visible pixels and a
// game-update strobe every next_duration+1 frames.
// Build macro VGA_SYNC_EN: when defined, adds registered active-low hsync/vsync
// outputs (one cycle behind row/col). When undefined the pixel driver derives
// sync from row/col itself.
module vga_controller
  import vga_pkg::*;
#(
  parameter int P_H_ACTIVE   = H_ACTIVE,
  parameter int P_H_TOTAL    = H_TOTAL,
  parameter int P_V_ACTIVE   = V_ACTIVE,
  parameter int P_V_TOTAL    = V_TOTAL,
  parameter int P_TILE_SHIFT = TILE_SHIFT,
  parameter int P_GRID_W     = GRID_W
`ifdef VGA_SYNC_EN
  ,
  parameter int P_H_FP       = H_FP,
  parameter int P_H_SW       = H_SYNC,
  parameter int P_V_FP       = V_FP,
  parameter int P_V_SW       = V_SYNC
`endif
) (
  input  logic               clk,
  input  logic               reset,          // synchronous, active-low
  input  logic [FRAME_W-1:0] next_duration,  // frames between updates, minus one
  output logic [CNT_W-1:0]   row,
  output logic [CNT_W-1:0]   col,
  output logic [CNT_W-1:0]   raddr,
  output logic               updateoutput,
  output logic               re
`ifdef VGA_SYNC_EN
  ,
  output logic               hsync,
  output logic               vsync
`endif
);

  pix_pos_t           w_pos;
  logic [CNT_W-1:0]   w_row;
  logic [CNT_W-1:0]   w_col;
  logic               w_vblank_start;
  logic               w_re;
  logic [CNT_W-1:0]   w_tile_row;
  logic [CNT_W-1:0]   w_tile_col;
  logic               w_strobe;
  logic [FRAME_W-1:0] r_frame;

  vga_timing #(
    .P_H_TOTAL  (P_H_TOTAL),
    .P_V_TOTAL  (P_V_TOTAL),
    .P_V_ACTIVE (P_V_ACTIVE)
  ) u_timing (
    .clk            (clk),
    .reset          (reset),
    .o_pos          (w_pos),
    .o_vblank_start (w_vblank_start)
  );

  assign w_row = w_pos.row;
  assign w_col = w_pos.col;

  // Read enable and tile address follow the counters with no added latency
  assign w_re       = (w_row < CNT_W'(P_V_ACTIVE)) && (w_col < CNT_W'(P_H_ACTIVE));
  assign w_tile_row = w_row >> P_TILE_SHIFT;
  assign w_tile_col = w_col >> P_TILE_SHIFT;

  assign row   = w_row;
  assign col   = w_col;
  assign re    = w_re;
  assign raddr = w_re ? (CNT_W'(w_tile_row * P_GRID_W) + w_tile_col) : '0;

  // next_duration only matters at vblank start; >= (not ==) means lowering it
  // below the running count fires on the very next frame instead of wrapping
  assign w_strobe     = w_vblank_start && (r_frame >= next_duration);
  assign updateoutput = w_strobe;

  // Frame counter: counts vblank starts, cleared on the cycle the strobe fires
  always_ff @(posedge clk) begin
    if (!reset)              r_frame <= '0;
    else if (w_vblank_start) r_frame <= w_strobe ? '0 : (r_frame + FRAME_W'(1));
  end

`ifdef VGA_SYNC_EN
  logic r_hsync;
  logic r_vsync;

  // Registered sync pulses, active-low inside the sync windows
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_hsync <= !((w_col >= CNT_W'(P_H_ACTIVE + P_H_FP)) &&
                   (w_col <= CNT_W'(P_H_ACTIVE + P_H_FP + P_H_SW - 1)));
      r_vsync <= !((w_row >= CNT_W'(P_V_ACTIVE + P_V_FP)) &&
                   (w_row <= CNT_W'(P_V_ACTIVE + P_V_FP + P_V_SW - 1)));
    end
  end

  assign hsync = r_hsync;
  assign vsync = r_vsync;
`endif

endmodule

// File: tb/tb_vga_controller.sv
// tb_vga_controller: checks a full-size instance (raster, tile addressing) and a
// shrunken-geometry instance (frame wrap, update strobe, mid-frame reset) against
// an arithmetic model of the raster position. Sync outputs are checked when
// VGA_SYNC_EN is defined.
module tb_vga_controller;

  localparam int NCYC = 81000;

  // Small instance geometry: 16x12 visible, 20x14 total, 4x4 tiles
  localparam int S_HA = 16, S_HT = 20, S_VA = 12, S_VT = 14, S_TILE = 4, S_GW = 4;

  logic       clk = 1'b0;
  logic       rst_b, rst_s;
  logic [4:0] nd;

  logic [9:0] b_row, b_col, b_raddr, s_row, s_col, s_raddr;
  logic       b_upd, b_re, s_upd, s_re;
`ifdef VGA_SYNC_EN
  logic       b_hs, b_vs, s_hs, s_vs;
`endif

  always #5 clk = ~clk;

  vga_controller u_big (
    .clk(clk), .reset(rst_b), .next_duration(nd),
    .row(b_row), .col(b_col), .raddr(b_raddr), .updateoutput(b_upd), .re(b_re)
`ifdef VGA_SYNC_EN
    , .hsync(b_hs), .vsync(b_vs)
`endif
  );

  vga_controller #(
    .P_H_ACTIVE(S_HA), .P_H_TOTAL(S_HT), .P_V_ACTIVE(S_VA), .P_V_TOTAL(S_VT),
    .P_TILE_SHIFT(2), .P_GRID_W(S_GW)
`ifdef VGA_SYNC_EN
    , .P_H_FP(2), .P_H_SW(2), .P_V_FP(1), .P_V_SW(1)
`endif
  ) u_small (
    .clk(clk), .reset(rst_s), .next_duration(nd),
    .row(s_row), .col(s_col), .raddr(s_raddr), .updateoutput(s_upd), .re(s_re)
`ifdef VGA_SYNC_EN
    , .hsync(s_hs), .vsync(s_vs)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state: pixel clocks since reset, frames since the last strobe
  int nb, ns, frames_b, frames_s;
  int pb_r, pb_c, ps_r, ps_c;       // positions before the edge
  int eb_r, eb_c, es_r, es_c;       // expected positions after the edge
  bit pb_vbs, ps_vbs;
  bit exp_bhs, exp_bvs, exp_shs, exp_svs;
  int vb_seen;
  bit lowered, expect_low;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(int r, int c, int ha, int va, int tile, int gw);
    if (r < va && c < ha) return (r / tile) * gw + (c / tile);
    return 0;
  endfunction

  initial begin
    rst_b = 1'b0; rst_s = 1'b0; nd = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_b_row", b_row, 0);     check("rst_b_col", b_col, 0);
    check("rst_b_re", b_re, 1);       check("rst_b_raddr", b_raddr, 0);
    check("rst_b_upd", b_upd, 0);
    check("rst_s_row", s_row, 0);     check("rst_s_col", s_col, 0);
    check("rst_s_re", s_re, 1);       check("rst_s_raddr", s_raddr, 0);
    check("rst_s_upd", s_upd, 0);
`ifdef VGA_SYNC_EN
    check("rst_b_hs", b_hs, 1); check("rst_b_vs", b_vs, 1);
    check("rst_s_hs", s_hs, 1); check("rst_s_vs", s_vs, 1);
`endif
    rst_b = 1'b1; rst_s = 1'b1;
    nb = 0; ns = 0; frames_b = 0; frames_s = 0;
    exp_bhs = 1; exp_bvs = 1; exp_shs = 1; exp_svs = 1;
    vb_seen = 0; lowered = 0; expect_low = 0;

    for (int k = 0; k < NCYC; k++) begin
      pb_r = (nb / 800) % 525;  pb_c = nb % 800;
      ps_r = (ns / S_HT) % S_VT; ps_c = ns % S_HT;
      pb_vbs = (pb_r == 480) && (pb_c == 0);
      ps_vbs = (ps_r == S_VA) && (ps_c == 0);

      @(posedge clk);
      #1;

      // Advance the models with the inputs that were present at the edge
      if (pb_vbs) frames_b = (frames_b >= nd) ? 0 : frames_b + 1;
      nb++;
      exp_bhs = !(pb_c >= 656 && pb_c <= 751);
      exp_bvs = !(pb_r >= 490 && pb_r <= 491);
      if (!rst_s) begin
        ns = 0; frames_s = 0; exp_shs = 1; exp_svs = 1;
      end else begin
        if (ps_vbs) frames_s = (frames_s >= nd) ? 0 : frames_s + 1;
        ns = (ns + 1) % (S_HT * S_VT);
        exp_shs = !(ps_c >= 18 && ps_c <= 19);
        exp_svs = !(ps_r == 13);
      end

      eb_r = (nb / 800) % 525;   eb_c = nb % 800;
      es_r = (ns / S_HT) % S_VT; es_c = ns % S_HT;

      check("b_row", b_row, eb_r);
      check("b_col", b_col, eb_c);
      check("b_re", b_re, (eb_r < 480 && eb_c < 640));
      check("b_raddr", b_raddr, exp_addr(eb_r, eb_c, 640, 480, 32, 20));
      check("b_upd", b_upd, (eb_r == 480 && eb_c == 0 && frames_b >= nd));
      check("s_row", s_row, es_r);
      check("s_col", s_col, es_c);
      check("s_re", s_re, (es_r < S_VA && es_c < S_HA));
      check("s_raddr", s_raddr, exp_addr(es_r, es_c, S_HA, S_VA, S_TILE, S_GW));
      check("s_upd", s_upd, (es_r == S_VA && es_c == 0 && frames_s >= nd));
`ifdef VGA_SYNC_EN
      check("b_hsync", b_hs, exp_bhs); check("b_vsync", b_vs, exp_bvs);
      check("s_hsync", s_hs, exp_shs); check("s_vsync", s_vs, exp_svs);
`endif

      // Directed spot checks on the full-size raster
      if (nb == 800) begin
        check("line1_row", b_row, 1); check("line1_col", b_col, 0);
      end
      if (nb == 33 * 800 + 70) begin
        check("pix33_70_raddr", b_raddr, 22); check("pix33_70_re", b_re, 1);
      end
      if (nb == 100 * 800 + 640) begin
        check("pix100_640_re", b_re, 0); check("pix100_640_raddr", b_raddr, 0);
      end

      if (es_r == S_VA && es_c == 0) begin
        vb_seen++;
        if (expect_low) begin
          check("nd_lowered_strobe", s_upd, 1);
          expect_low = 0;
        end
      end

      // Stimulus for the next edge; next_duration only moves away from vblank start
      rst_s = 1'b1;
      if (es_c == 1) begin
        if (vb_seen < 4)       nd = 5'd0;
        else if (vb_seen < 12) nd = 5'd2;
        else if (!lowered) begin
          nd = 5'd31;
          if (frames_s == 5) begin
            nd = 5'd1; lowered = 1; expect_low = 1;
          end
        end else if (!expect_low && $urandom_range(0, 199) == 0) begin
          nd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                           : 5'($urandom_range(0, 3));
        end
      end
      if (lowered && !expect_low && $urandom_range(0, 2999) == 0) rst_s = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
